inst_loader: RTL
================

# inst_loader

Instruction-memory loader: the write side of the instruction fetch path. It receives a byte stream over a valid/ready handshake, reassembles 9-bit instructions, and writes them to sequential instruction-memory addresses starting at 0. It verifies a trailing XOR checksum and holds the program counter at its start condition via `Start` until a clean load completes.

## Interface
- `ADDR_W`, 10: instruction address width; memory depth is 2**ADDR_W.
- `INST_W`, 9: instruction width. Fixed at 9 by the framing; other values are unsupported.

- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Load`  in  1  request a load session; sampled only in IDLE, DONE and ERR.
- `InByte`  in  8  stream byte.
- `InValid`  in  1  `InByte` is valid.
- `InReady`  out  1  loader accepts a byte this cycle.
- `WrEn`  out  1  instruction-memory write strobe, one cycle per instruction.
- `WrAddr`  out  ADDR_W  write address.
- `WrData`  out  INST_W  write data.
- `Start`  out  1  to the program counter. High holds the PC at its start; low releases it.
- `Done`  out  1  load completed with a good checksum.
- `Err`  out  1  load failed (checksum mismatch or overflow).
- `Count`  out  ADDR_W+1  number of instructions written in the current or last session.

## Operation
- A byte is accepted on any cycle where `InValid && InReady`. `InReady` is high only in HI, LO and CHK.
- Each instruction uses two bytes, in this order:
  - Hi byte: bit7 is LAST and bit0 is inst[8]. Bits 6:1 are ignored but are included in the checksum.
  - Lo byte: inst[7:0].
- After the instruction flagged LAST, one checksum byte follows. It must equal the XOR of every hi and lo byte in the session.
- States and transitions:
  - IDLE: on `Load`, go to HI. Clear address, `Count` and checksum.
  - HI: on accept, latch LAST and inst[8], XOR into the checksum, go to LO.
  - LO: on accept, register the write, XOR into the checksum, then go to:
    - CHK if LAST is set;
    - ERR if the write address is 2**ADDR_W-1 and LAST is clear (overflow);
    - HI otherwise.
  - CHK: on accept, go to DONE if the byte equals the checksum, else ERR.
  - DONE and ERR: on `Load`, clear address, `Count`, checksum, `Done` and `Err`, then go to HI.
- `Load` is ignored in HI, LO and CHK.
- Write address starts at 0 and increments by 1 after each write. It never wraps; the overflow rule above stops the session first.
- `Count` increments together with each `WrEn` pulse and saturates by construction at 2**ADDR_W.
- Memory contents are never cleared by reset or `Load`.
- Outputs by state:
  - `Start` = 0 only in DONE; 1 in every other state.
  - `Done` = 1 only in DONE.
  - `Err` = 1 only in ERR.
- Reset values: state IDLE, `InReady`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `Start`=1, `Done`=0, `Err`=0, `Count`=0, checksum 0.

## Timing
- `WrEn`, `WrAddr`, `WrData` and `Count` are registered.
  - `WrEn` is high for exactly one cycle, the cycle after the lo-byte accept.
  - `WrAddr`/`WrData` are valid during that cycle.
  - `Count` shows the new value in the same cycle as `WrEn`.
- `InReady` is a registered function of state and has no combinational path from `InValid`.
- Back-to-back bytes are accepted with no bubbles, giving one instruction per 2 cycles.
- `Done`/`Err`/`Start` change in the cycle after the checksum byte is accepted.
- On overflow, `Err` asserts in the same cycle as the final `WrEn`. No further write occurs.
- Gaps in `InValid` stall the FSM in place; no state, counter or checksum change occurs while `InValid`=0.
- Asynchronous `Reset` low at any point, including mid-instruction:
  - all registers return to reset values immediately and `WrEn` drops;
  - a half-received instruction is discarded.

## Test plan
- Reset values: hold `Reset`=0, then release. Expect `Start`=1, `Done`=0, `Err`=0, `Count`=0, `WrEn`=0, `InReady`=0 until `Load`.
- Good load: pulse `Load`, then send 01 A5 00 F0 81 00 D5. Expect:
  - `WrEn` pulses writing 0x1A5@0, 0x0F0@1, 0x100@2;
  - then `Done`=1, `Start`=0, `Count`=3.
- Bad checksum: same stream ending in D4 instead of D5. Expect the same three writes, then `Err`=1, `Done`=0, `Start`=1.
- Stalls: good-load stream with `InValid` dropped for 3 cycles between each byte. Expect identical writes, no extra `WrEn`, and `Done`=1.
- Overflow: 1024 instructions, none flagged LAST. Expect writes at 0..1023, `Err`=1 with the write to 1023, `Count`=1024, and no write afterwards.
- Reset mid-load: send 01 A5 00, assert `Reset`, release, then run the good load. Expect `Count`=0 after reset, and the first write of the new session lands at address 0.

Source files
------------

// File: rtl/inst_loader.sv
// Instruction-memory loader: rebuilds 9-bit instructions from a byte stream,
// writes them from address 0 upward and releases the PC on a good checksum.
//
// Ports:
//   Clk, Reset (async, active-low)
//   Load                 start a session (IDLE/DONE/ERR only)
//   InByte/InValid/InReady  byte stream handshake
//   WrEn/WrAddr/WrData   instruction-memory write port
//   Start                PC hold (low only after a good load)
//   Done/Err             session result
//   Count                instructions written this session
module inst_loader #(
  parameter int ADDR_W = 10,
  parameter int INST_W = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic [7:0]        InByte,
  input  logic              InValid,
  output logic              InReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [INST_W-1:0] WrData,
  output logic              Start,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W:0]   Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Count doubles as the next write address; the session stops
  // with an error once the top address has been written.
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_last;
  logic                r_inst8;
  logic [7:0]          r_csum;
  logic                r_ready;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_waddr;
  logic [INST_W-1:0]   r_wdata;
  logic                r_start;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_cnt;

  logic                w_acc;
  logic [7:0]          w_csum_nxt;

  assign w_acc      = InValid & r_ready;
  assign w_csum_nxt = r_csum ^ InByte;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
      r_inst8 <= 1'b0;
      r_csum  <= 8'h00;
      r_ready <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_start <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wen <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (Load) begin
            r_state <= S_HI;
            r_ready <= 1'b1;
            r_csum  <= 8'h00;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_start <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_HI: begin
          if (w_acc) begin
            r_last  <= InByte[7];
            r_inst8 <= InByte[0];
            r_csum  <= w_csum_nxt;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_acc) begin
            r_wen   <= 1'b1;
            r_waddr <= r_cnt[ADDR_W-1:0];
            r_wdata <= {r_inst8, InByte};
            r_cnt   <= r_cnt + CNT_ONE;
            r_csum  <= w_csum_nxt;
            if (r_last) begin
              r_state <= S_CHK;
            end else if (r_cnt == LAST_ADDR) begin
              // Memory full without LAST: error shows with the final write.
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_HI;
            end
          end
        end
        S_CHK: begin
          if (w_acc) begin
            r_ready <= 1'b0;
            if (InByte == r_csum) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_start <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign InReady = r_ready;
  assign WrEn    = r_wen;
  assign WrAddr  = r_waddr;
  assign WrData  = r_wdata;
  assign Start   = r_start;
  assign Done    = r_done;
  assign Err     = r_err;
  assign Count   = r_cnt;

endmodule
